// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mips_cpu_pkg : shared MIPS pipeline types (load kinds, registers, words)
// Revision     : 1.0
// ============================================================================
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] double_word_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } ldtype_enum;

    typedef enum logic [4:0] {
        R_ZERO, R_AT, R_V0, R_V1, R_A0, R_A1, R_A2, R_A3,
        R_T0,   R_T1, R_T2, R_T3, R_T4, R_T5, R_T6, R_T7,
        R_S0,   R_S1, R_S2, R_S3, R_S4, R_S5, R_S6, R_S7,
        R_T8,   R_T9, R_K0, R_K1, R_GP, R_SP, R_FP, R_RA
    } reg_enum;

    // data carries alures until a load response overwrites it with raw memory data
    typedef struct packed {
        logic         dm2rf;
        logic         hilowe;
        logic         rfwe;
        logic         done;
        ldtype_enum   ldtype;
        logic [1:0]   addrlo;
        reg_enum      rfwa;
        word_t        data;
        double_word_t mulres;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// wb_load_align : little-endian load lane select with sign/zero extension
// Revision      : 1.0
// ============================================================================
module wb_load_align
    import mips_cpu_pkg::*;
(
    input  ldtype_enum ldtype_i,
    input  logic [1:0] addrlo_i,
    input  word_t      rdata_i,
    output word_t      word_o,
    output logic       misalign_o
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane selects ignore the low address bits a wider access cannot use,
    // which is exactly the "offending bits cleared" behaviour on misalignment.
    always_comb begin
        w_half = addrlo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addrlo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
    end

    always_comb begin
        word_o     = rdata_i;
        misalign_o = 1'b0;
        case (ldtype_i)
            LD_LW:  misalign_o = (addrlo_i != 2'b00);
            LD_LH:  begin
                misalign_o = addrlo_i[0];
                word_o     = {{16{w_half[15]}}, w_half};
            end
            LD_LHU: begin
                misalign_o = addrlo_i[0];
                word_o     = {16'h0000, w_half};
            end
            LD_LB:  word_o = {{24{w_byte[7]}}, w_byte};
            LD_LBU: word_o = {24'h000000, w_byte};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stage_wb_q.sv
`default_nettype none
// ============================================================================
// stage_wb_q : in-order writeback queue with out-of-band load data return
// Revision   : 1.0
// ============================================================================
module stage_wb_q
    import mips_cpu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_i_valid,
    output logic                   wb_o_ready,
    input  logic                   wb_i_dm2rf,
    input  logic                   wb_i_hilowe,
    input  logic                   wb_i_rfwe,
    input  ldtype_enum             wb_i_ldtype,
    input  logic [1:0]             wb_i_addrlo,
    input  reg_enum                wb_i_rfwa,
    input  word_t                  wb_i_alures,
    input  double_word_t           wb_i_mulres,
    input  logic                   dm_rvalid,
    input  word_t                  dm_rdata,
    output logic                   rfwe,
    output reg_enum                rfwa,
    output word_t                  rfwd,
    output logic                   hilowe,
    output word_t                  hi_i,
    output word_t                  lo_i,
    output logic                   wb_o_busy,
    output logic [$clog2(DEPTH):0] wb_o_count,
    output logic                   wb_o_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, w_match_idx;
    logic [CW-1:0] count_q, count_d;
    logic          rfwe_q, hilowe_q, err_q, err_d;
    reg_enum       rfwa_q;
    word_t         rfwd_q, hi_q, lo_q, w_ld_word, w_rfwd;
    wb_entry_t     w_ent [DEPTH];
    wb_entry_t     w_head, w_new;
    logic          w_full, w_enq, w_retire, w_match, w_resp, w_misalign, w_err_evt;

    assign w_full   = (count_q == c_full_cnt);
    assign w_enq    = wb_i_valid && !w_full;
    assign w_head   = w_ent[head_q];
    assign w_retire = (count_q != '0) && w_head.done;

    always_comb begin
        w_new        = '0;
        w_new.dm2rf  = wb_i_dm2rf;
        w_new.hilowe = wb_i_hilowe;
        w_new.rfwe   = wb_i_rfwe;
        w_new.done   = !wb_i_dm2rf;
        w_new.ldtype = wb_i_ldtype;
        w_new.addrlo = wb_i_addrlo;
        w_new.rfwa   = wb_i_rfwa;
        w_new.data   = wb_i_alures;
        w_new.mulres = wb_i_mulres;
    end

    // Oldest pending load, scanned from head; this cycle's enqueue is not yet visible here.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_match && (CW'(k) < count_q) &&
                w_ent[head_q + PW'(k)].dm2rf && !w_ent[head_q + PW'(k)].done) begin
                w_match     = 1'b1;
                w_match_idx = head_q + PW'(k);
            end
        end
    end

    assign w_resp = dm_rvalid && w_match;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        wb_entry_t ent_q, ent_d;
        always_comb begin
            ent_d = ent_q;
            if (w_enq && (tail_q == PW'(e))) begin
                ent_d = w_new;
            end else if (w_resp && (w_match_idx == PW'(e))) begin
                ent_d.done = 1'b1;
                ent_d.data = dm_rdata;
            end
        end
        always_ff @(posedge clk) begin
            if (rst) ent_q <= '0;
            else     ent_q <= ent_d;
        end
        assign w_ent[e] = ent_q;
    end

    wb_load_align u_align (
        .ldtype_i   (w_head.ldtype),
        .addrlo_i   (w_head.addrlo),
        .rdata_i    (w_head.data),
        .word_o     (w_ld_word),
        .misalign_o (w_misalign)
    );

    assign w_rfwd    = w_head.dm2rf ? w_ld_word : w_head.data;
    assign w_err_evt = (dm_rvalid && !w_match) ||
                       (w_retire && w_head.dm2rf && w_misalign);

    always_comb begin
        head_d  = head_q + PW'(w_retire);
        tail_d  = tail_q + PW'(w_enq);
        count_d = count_q + CW'(w_enq) - CW'(w_retire);
        err_d   = ERR_STICKY ? (err_q | w_err_evt) : w_err_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rfwe_q   <= 1'b0;
            hilowe_q <= 1'b0;
            rfwa_q   <= R_ZERO;
            rfwd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
            rfwe_q   <= w_retire && w_head.rfwe && (w_head.rfwa != R_ZERO);
            hilowe_q <= w_retire && w_head.hilowe;
            if (w_retire) begin
                rfwa_q <= w_head.rfwa;
                rfwd_q <= w_rfwd;
                hi_q   <= w_head.mulres[63:32];
                lo_q   <= w_head.mulres[31:0];
            end
        end
    end

    assign wb_o_ready = !w_full;
    assign wb_o_busy  = (count_q != '0);
    assign wb_o_count = count_q;
    assign wb_o_err   = err_q;
    assign rfwe       = rfwe_q;
    assign rfwa       = rfwa_q;
    assign rfwd       = rfwd_q;
    assign hilowe     = hilowe_q;
    assign hi_i       = hi_q;
    assign lo_i       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_wb_q.sv
`default_nettype none
// ============================================================================
// tb_stage_wb_q : directed + randomized bench against a queue-level model
// Revision      : 1.0
// ============================================================================
module tb_stage_wb_q;
    import mips_cpu_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, wb_i_valid, wb_o_ready, wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe;
    ldtype_enum   wb_i_ldtype;
    logic [1:0]   wb_i_addrlo;
    reg_enum      wb_i_rfwa, rfwa;
    word_t        wb_i_alures, dm_rdata, rfwd, hi_i, lo_i;
    double_word_t wb_i_mulres;
    logic         dm_rvalid, rfwe, hilowe, wb_o_busy, wb_o_err;
    logic [2:0]   wb_o_count;

    stage_wb_q #(.DEPTH(DEPTH), .ERR_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .wb_i_valid(wb_i_valid), .wb_o_ready(wb_o_ready),
        .wb_i_dm2rf(wb_i_dm2rf), .wb_i_hilowe(wb_i_hilowe), .wb_i_rfwe(wb_i_rfwe),
        .wb_i_ldtype(wb_i_ldtype), .wb_i_addrlo(wb_i_addrlo), .wb_i_rfwa(wb_i_rfwa),
        .wb_i_alures(wb_i_alures), .wb_i_mulres(wb_i_mulres), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd), .hilowe(hilowe),
        .hi_i(hi_i), .lo_i(lo_i), .wb_o_busy(wb_o_busy), .wb_o_count(wb_o_count),
        .wb_o_err(wb_o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        dm2rf, hilowe, rfwe, done;
        ldtype_enum  ld;
        logic [1:0]  addr;
        logic [4:0]  ra;
        logic [31:0] alures, rdata;
        logic [63:0] mul;
    } ment_t;

    ment_t       mq[$];
    logic        m_rfwe = 1'b0, m_hilowe = 1'b0, m_err = 1'b0;
    logic [4:0]  m_rfwa = '0;
    logic [31:0] m_rfwd = '0, m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Shift-and-mask view of a little-endian load; sign extension by modular subtraction.
    function automatic logic [31:0] ref_load(input ldtype_enum t, input logic [1:0] a,
                                             input logic [31:0] d, output logic mis);
        logic [31:0] v;
        int          ofs;
        mis = 1'b0;
        if (t == LD_LW) begin
            mis = (a != 2'b00);
            return d;
        end
        if (t == LD_LH || t == LD_LHU) begin
            mis = a[0];
            ofs = a[1] ? 16 : 0;
            v   = (d >> ofs) & 32'h0000_FFFF;
            if (t == LD_LH && v >= 32'h8000) v = v - 32'h0001_0000;
            return v;
        end
        ofs = int'(a) * 8;
        v   = (d >> ofs) & 32'h0000_00FF;
        if (t == LD_LB && v >= 32'h80) v = v - 32'h100;
        return v;
    endfunction

    task automatic model_step();
        int    pre_size, match;
        logic  evt, mis;
        ment_t h, e;
        if (rst) begin
            mq.delete();
            {m_rfwe, m_hilowe, m_err} = '0;
            m_rfwa = '0; m_rfwd = '0; m_hi = '0; m_lo = '0;
            return;
        end
        pre_size = mq.size();
        evt      = 1'b0;
        match    = -1;
        for (int i = 0; i < pre_size; i++)
            if (match < 0 && mq[i].dm2rf && !mq[i].done) match = i;
        if (dm_rvalid) begin
            if (match >= 0) begin
                mq[match].done  = 1'b1;
                mq[match].rdata = dm_rdata;
            end else evt = 1'b1;
        end
        if (pre_size > 0 && mq[0].done && !(match == 0)) begin
            h        = mq.pop_front();
            m_rfwd   = h.dm2rf ? ref_load(h.ld, h.addr, h.rdata, mis) : h.alures;
            if (h.dm2rf && mis) evt = 1'b1;
            m_rfwe   = h.rfwe && (h.ra != 5'd0);
            m_rfwa   = h.ra;
            m_hilowe = h.hilowe;
            m_hi     = h.mul[63:32];
            m_lo     = h.mul[31:0];
        end else begin
            m_rfwe   = 1'b0;
            m_hilowe = 1'b0;
        end
        if (wb_i_valid && pre_size < DEPTH) begin
            e.dm2rf = wb_i_dm2rf; e.hilowe = wb_i_hilowe; e.rfwe = wb_i_rfwe;
            e.done  = !wb_i_dm2rf; e.ld = wb_i_ldtype; e.addr = wb_i_addrlo;
            e.ra    = 5'(wb_i_rfwa); e.alures = wb_i_alures; e.rdata = '0;
            e.mul   = wb_i_mulres;
            mq.push_back(e);
        end
        m_err = m_err | evt;
    endtask

    task automatic check_outputs();
        chk("rfwe",   64'(rfwe),       64'(m_rfwe));
        chk("rfwa",   64'(rfwa),       64'(m_rfwa));
        chk("rfwd",   64'(rfwd),       64'(m_rfwd));
        chk("hilowe", 64'(hilowe),     64'(m_hilowe));
        chk("hi_i",   64'(hi_i),       64'(m_hi));
        chk("lo_i",   64'(lo_i),       64'(m_lo));
        chk("count",  64'(wb_o_count), 64'(mq.size()));
        chk("busy",   64'(wb_o_busy),  64'(mq.size() != 0));
        chk("ready",  64'(wb_o_ready), 64'(mq.size() < DEPTH));
        chk("err",    64'(wb_o_err),   64'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        rst = 1'b0; wb_i_valid = 1'b0; dm_rvalid = 1'b0;
    endtask

    task automatic offer(input logic dm2rf, input ldtype_enum ld, input logic [1:0] a,
                         input logic [4:0] ra, input logic [31:0] alu, input logic hl,
                         input logic [63:0] mul, input logic we);
        idle();
        wb_i_valid = 1'b1; wb_i_dm2rf = dm2rf; wb_i_ldtype = ld; wb_i_addrlo = a;
        wb_i_rfwa = reg_enum'(ra); wb_i_alures = alu; wb_i_hilowe = hl;
        wb_i_mulres = mul; wb_i_rfwe = we;
    endtask

    task automatic load_one(input ldtype_enum ld, input logic [1:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input string nm);
        offer(1'b1, ld, a, 5'd7, 32'h0, 1'b0, 64'h0, 1'b1);
        step();
        idle(); dm_rvalid = 1'b1; dm_rdata = d;
        step();
        idle();
        step();
        chk(nm, 64'(rfwd), 64'(exp));
        chk({nm, "_we"}, 64'(rfwe), 64'd1);
    endtask

    initial begin
        rst = 1'b1; wb_i_valid = 1'b0; wb_i_dm2rf = 1'b0; wb_i_hilowe = 1'b0;
        wb_i_rfwe = 1'b0; wb_i_ldtype = LD_LW; wb_i_addrlo = '0; wb_i_rfwa = R_ZERO;
        wb_i_alures = '0; wb_i_mulres = '0; dm_rvalid = 1'b0; dm_rdata = '0;
        step(); step();
        chk("rst_count", 64'(wb_o_count), 64'd0);
        chk("rst_ready", 64'(wb_o_ready), 64'd1);
        idle();

        // ALU write lands exactly two cycles after the enqueue cycle
        offer(1'b0, LD_LW, 2'd0, 5'd5, 32'h1234_5678, 1'b0, 64'h0, 1'b1);
        step();
        chk("alu_t1_we", 64'(rfwe), 64'd0);
        idle(); step();
        chk("alu_t2_we", 64'(rfwe), 64'd1);
        chk("alu_t2_wa", 64'(rfwa), 64'd5);
        chk("alu_t2_wd", 64'(rfwd), 64'h1234_5678);
        step();
        chk("alu_t3_we", 64'(rfwe), 64'd0);

        load_one(LD_LB,  2'd3, 32'h80AA_BBCC, 32'hFFFF_FF80, "lb3");
        load_one(LD_LHU, 2'd2, 32'h80AA_BBCC, 32'h0000_80AA, "lhu2");
        load_one(LD_LBU, 2'd1, 32'h80AA_BBCC, 32'h0000_00BB, "lbu1");

        // late load data holds back a younger ALU op
        offer(1'b1, LD_LW, 2'd0, 5'd1, 32'h0, 1'b0, 64'h0, 1'b1); step();
        offer(1'b0, LD_LW, 2'd0, 5'd2, 32'h0000_000B, 1'b0, 64'h0, 1'b1); step();
        idle(); repeat (4) step();
        dm_rvalid = 1'b1; dm_rdata = 32'hAAAA_0001; step();
        idle(); step();
        chk("ord_a_wa", 64'(rfwa), 64'd1);
        chk("ord_a_wd", 64'(rfwd), 64'hAAAA_0001);
        step();
        chk("ord_b_wa", 64'(rfwa), 64'd2);
        chk("ord_b_wd", 64'(rfwd), 64'h0000_000B);

        // fill to DEPTH with pending loads, then drain in order
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, LD_LW, 2'd0, 5'(10 + i), 32'h0, 1'b0, 64'h0, 1'b1);
            step();
        end
        chk("full_count", 64'(wb_o_count), 64'd4);
        chk("full_ready", 64'(wb_o_ready), 64'd0);
        offer(1'b0, LD_LW, 2'd0, 5'd20, 32'hDEAD_0000, 1'b0, 64'h0, 1'b1); step();
        chk("full_5th", 64'(wb_o_count), 64'd4);
        for (int k = 0; k < 4; k++) begin
            idle(); dm_rvalid = 1'b1; dm_rdata = 32'h100 + 32'(k);
            step();
            if (k > 0) chk("drain_wa", 64'(rfwa), 64'(10 + k - 1));
        end
        idle(); step();
        chk("drain_last", 64'(rfwd), 64'h103);
        chk("drain_cnt", 64'(wb_o_count), 64'd0);
        chk("no_err_yet", 64'(wb_o_err), 64'd0);

        // misaligned LH at 3 reads halfword at 2 and flags error
        load_one(LD_LH, 2'd3, 32'h80AA_BBCC, 32'hFFFF_80AA, "lh_mis");
        chk("mis_err", 64'(wb_o_err), 64'd1);

        rst = 1'b1; step(); idle(); step();
        chk("err_clr", 64'(wb_o_err), 64'd0);
        dm_rvalid = 1'b1; dm_rdata = 32'h5; step();
        chk("orphan_err", 64'(wb_o_err), 64'd1);
        idle(); step();
        chk("err_sticky", 64'(wb_o_err), 64'd1);
        offer(1'b0, LD_LW, 2'd0, 5'd0, 32'h55, 1'b0, 64'h0, 1'b1); step();
        idle(); step();
        chk("r0_we", 64'(rfwe), 64'd0);
        chk("r0_wd", 64'(rfwd), 64'h55);
        offer(1'b0, LD_LW, 2'd0, 5'd3, 32'h0, 1'b1, 64'h1_0000_0002, 1'b0); step();
        idle(); step();
        chk("hl_we", 64'(hilowe), 64'd1);
        chk("hl_hi", 64'(hi_i), 64'd1);
        chk("hl_lo", 64'(lo_i), 64'd2);

        // reset with three entries queued and data arriving in the reset cycle
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, LD_LW, 2'd0, 5'(4 + i), 32'h0, 1'b1, 64'h7, 1'b1);
            step();
        end
        idle(); rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h9; step();
        idle(); step();
        chk("rst3_count", 64'(wb_o_count), 64'd0);
        chk("rst3_ready", 64'(wb_o_ready), 64'd1);
        repeat (3) step();
        chk("rst3_we", 64'({rfwe, hilowe}), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            wb_i_valid   = $urandom_range(0, 1) == 1;
            wb_i_dm2rf   = $urandom_range(0, 1) == 1;
            wb_i_hilowe  = $urandom_range(0, 3) == 0;
            wb_i_rfwe    = $urandom_range(0, 3) != 0;
            wb_i_ldtype  = ldtype_enum'(3'($urandom_range(0, 4)));
            wb_i_addrlo  = 2'($urandom_range(0, 3));
            wb_i_rfwa    = reg_enum'(5'($urandom_range(0, 31)));
            wb_i_alures  = $urandom;
            wb_i_mulres  = {$urandom, $urandom};
            dm_rvalid    = $urandom_range(0, 9) < 3;
            dm_rdata     = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_wb_q.md
STAGE_WB_Q -- requirements
Module: stage_wb_q

Interface
REQ-001 SHALL have parameter DEPTH, default 4, writeback queue entries; power of two, >= 2.
REQ-002 SHALL have parameter ERR_STICKY, default 1; 1 = error flag held until reset, 0 = one-cycle pulse.
REQ-003 SHALL use one clock and a synchronous, active-high reset: ports clk and rst, clk first.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wb_i_valid  in  1  memwb entry offered.
REQ-007 wb_o_ready  out  1  queue accepts entry; equals !full.
REQ-008 wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe  in  1 each  load / hilo write / regfile write.
REQ-009 wb_i_ldtype  in  ldtype_enum  LW, LH, LHU, LB, LBU.
REQ-010 wb_i_addrlo  in  2  load address bits [1:0].
REQ-011 wb_i_rfwa  in  reg_enum;  wb_i_alures  in  word_t;  wb_i_mulres  in  double_word_t.
REQ-012 dm_rvalid  in  1;  dm_rdata  in  word_t  in-order load response.
REQ-013 rfwe  out  1;  rfwa  out  reg_enum;  rfwd  out  word_t  regfile write port.
REQ-014 hilowe  out  1;  hi_i, lo_i  out  word_t  HI/LO write port.
REQ-015 wb_o_busy  out  1  queue non-empty;  wb_o_count  out  $clog2(DEPTH)+1  occupancy.
REQ-016 wb_o_err  out  1  protocol/alignment error.

Function
REQ-017 Enqueue at tail SHALL occur when wb_i_valid && wb_o_ready; when full, no enqueue even if head retires that cycle.
REQ-018 Each entry SHALL hold all wb_i_* fields plus done flag; done=1 at enqueue if wb_i_dm2rf=0, else 0.
REQ-019 dm_rvalid SHALL deliver dm_rdata to oldest queued entry with dm2rf=1 && done=0, setting done; an entry enqueued in the same cycle is not eligible.
REQ-020 dm_rvalid with no eligible entry SHALL be dropped and raise wb_o_err.
REQ-021 Head SHALL retire in any cycle where it is valid and done; at most one retire per cycle; strict in-order.
REQ-022 Outputs SHALL be registered: retire in cycle T drives rfwe/hilowe and data in T+1, deasserted T+2 unless another retire.
REQ-023 Min latency: non-load enqueued at T -> retire T+1 -> outputs T+2; load data at T -> done T+1 -> retire T+1 if head -> outputs T+2.
REQ-024 rfwe SHALL be forced 0 when entry rfwa is register zero; rfwa/rfwd still driven.
REQ-025 rfwd SHALL be aligned load data if dm2rf=1, else alures.
REQ-026 Load alignment little-endian: LW whole word; LH/LHU halfword addrlo[1]; LB/LBU byte addrlo; LH/LB sign-extend, LHU/LBU zero-extend.
REQ-027 Misaligned load (LW addrlo!=0, LH/LHU addrlo[0]=1) SHALL raise wb_o_err at retire and use addrlo with offending low bits cleared.
REQ-028 hi_i = mulres[63:32], lo_i = mulres[31:0], hilowe pulse per REQ-022; rfwe and hilowe may assert together.
REQ-029 head/tail pointers SHALL wrap modulo DEPTH; count SHALL change by enq-retire, never exceeding DEPTH or below 0.
REQ-030 wb_o_err per ERR_STICKY: sticky until rst, or pulsed one cycle per event.

Reset
REQ-031 rst SHALL clear all entries, pointers, count, done flags; rfwe=0, hilowe=0, rfwa=0, rfwd=0, hi_i=0, lo_i=0, wb_o_err=0, wb_o_busy=0, wb_o_ready=1 next cycle.
REQ-032 rst mid-operation SHALL discard queued entries without any write; dm_rvalid in the reset cycle ignored.

Structure
REQ-033 ldtype_enum, reg_enum, word_t, double_word_t SHALL live in mips_cpu_pkg.
REQ-034 Alignment/extension SHALL be sub-module wb_load_align (combinational: ldtype, addrlo, rdata -> word, misalign).

Verification
REQ-035 ALU op rfwa=5, alures=0x1234_5678 at T -> rfwe=1, rfwa=5, rfwd=0x1234_5678 at T+2 only.
REQ-036 LB addrlo=3, dm_rdata=0x80AA_BBCC -> rfwd=0xFFFF_FF80; LHU addrlo=2 same data -> 0x0000_80AA.
REQ-037 Enqueue load A then ALU B; data for A arrives 5 cycles later -> B written only cycle after A, in order.
REQ-038 DEPTH=4, four loads, no data -> wb_o_ready=0, count=4; 5th offer not accepted; data returns -> all four retire in order.
REQ-039 dm_rvalid with empty queue -> wb_o_err=1 (sticky); rfwa=0 write -> rfwe stays 0; mulres=0x1_0000_0002 hilowe -> hi_i=1, lo_i=2.
REQ-040 rst asserted with 3 entries queued -> no rfwe/hilowe afterwards, count=0, wb_o_ready=1.
